// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: fetches sequentially from instruction memory into a
// small FIFO and discards in-flight or buffered instructions on a redirect.
module prefetch_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [ADDR_WIDTH-1:0]  boot_addr_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   imem_ack_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_ready_i
);

  localparam int INC = INSTR_WIDTH / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DISCARD} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0]  discard_addr_reg, discard_addr_next;
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]            count_reg, count_next;
  logic [INSTR_WIDTH-1:0] instr_mem_reg [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_mem_reg  [DEPTH];

  logic ack_acc;
  logic push;
  logic pop;
  logic flush;

  // DISCARD keeps presenting the abandoned address until memory completes it.
  assign imem_req_o  = (state_reg == DISCARD) || ((state_reg == RUN) && (count_reg < DEPTH_C));
  assign imem_addr_o = (state_reg == DISCARD) ? discard_addr_reg : fetch_pc_reg;
  assign ack_acc     = imem_req_o && imem_ack_i;

  assign instr_valid_o = (count_reg != '0);
  assign instr_o       = instr_mem_reg[rd_ptr_reg];
  assign instr_addr_o  = addr_mem_reg[rd_ptr_reg];
  assign pop           = instr_valid_o && instr_ready_i && !flush;

  always_comb begin
    state_next        = state_reg;
    fetch_pc_next     = fetch_pc_reg;
    discard_addr_next = discard_addr_reg;
    push              = 1'b0;
    flush             = 1'b0;
    case (state_reg)
      BOOT: begin
        fetch_pc_next = redirect_i ? redirect_addr_i : boot_addr_i;
        state_next    = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_addr_i;
          if (imem_req_o && !imem_ack_i) begin
            state_next        = DISCARD;
            discard_addr_next = fetch_pc_reg;
          end
        end else if (ack_acc) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(INC);
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_addr_i;
        end
        // The stale response is dropped; completing it ends the discard.
        if (ack_acc) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg        <= BOOT;
      fetch_pc_reg     <= '0;
      discard_addr_reg <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_reg[i] <= '0;
        addr_mem_reg[i]  <= '0;
      end
    end else begin
      state_reg        <= state_next;
      fetch_pc_reg     <= fetch_pc_next;
      discard_addr_reg <= discard_addr_next;
      count_reg        <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
      if (push) begin
        instr_mem_reg[wr_ptr_reg] <= imem_rdata_i;
        addr_mem_reg[wr_ptr_reg]  <= fetch_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: boot, backpressure, wait states, redirects,
// address wrap (8-bit instance) and reset in the middle of a fill.
module tb_prefetch_unit;

  logic        clk;
  logic        arst_n;
  logic [31:0] boot_addr;
  logic        req;
  logic [31:0] addr;
  logic [15:0] rdata;
  logic        ack;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        valid;
  logic [15:0] instr;
  logic [31:0] instr_addr;
  logic        ready;

  logic [7:0]  boot8;
  logic        req8;
  logic [7:0]  addr8;
  logic [15:0] rdata8;
  logic        ack8;
  logic        redirect8;
  logic [7:0]  redirect_addr8;
  logic        valid8;
  logic [15:0] instr8;
  logic [7:0]  instr_addr8;
  logic        ready8;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory models: data is a fixed function of the address.
  assign rdata  = addr[15:0] ^ 16'hA5A5;
  assign rdata8 = {addr8, ~addr8};

  prefetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(16), .DEPTH(4)) dut (
    .clk_i(clk), .arst_ni(arst_n), .boot_addr_i(boot_addr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ack_i(ack),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .instr_valid_o(valid), .instr_o(instr), .instr_addr_o(instr_addr),
    .instr_ready_i(ready)
  );

  prefetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(4)) dut8 (
    .clk_i(clk), .arst_ni(arst_n), .boot_addr_i(boot8),
    .imem_req_o(req8), .imem_addr_o(addr8), .imem_rdata_i(rdata8), .imem_ack_i(ack8),
    .redirect_i(redirect8), .redirect_addr_i(redirect_addr8),
    .instr_valid_o(valid8), .instr_o(instr8), .instr_addr_o(instr_addr8),
    .instr_ready_i(ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arst_n && req && ack) $display("txn: fetch addr=%h data=%h", addr, rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    boot_addr = 32'h100;
    arst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", req); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr); end
    n_checks++; if (instr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr got %h exp 0", instr_addr); end
    n_checks++; if (req8 !== 1'b0) begin n_fail++; $display("FAIL reset_req8 got %b exp 0", req8); end
  endtask

  task automatic test_boot();
    logic [31:0] exp_a;
    logic [31:0] exp_h;
    boot_addr = 32'h100; ack = 1'b1; ready = 1'b1;
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_a = 32'h100 + 32'(2 * k);
      n_checks++; if ({req, addr} !== {1'b1, exp_a}) begin n_fail++; $display("FAIL boot_req%0d got %b/%h exp 1/%h", k, req, addr, exp_a); end
      if (k > 0) begin
        exp_h = exp_a - 32'h2;
        n_checks++; if ({valid, instr_addr} !== {1'b1, exp_h}) begin n_fail++; $display("FAIL boot_head%0d got %b/%h exp 1/%h", k, valid, instr_addr, exp_h); end
        n_checks++; if (instr !== (exp_h[15:0] ^ 16'hA5A5)) begin n_fail++; $display("FAIL boot_instr%0d got %h exp %h", k, instr, exp_h[15:0] ^ 16'hA5A5); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    boot_addr = 32'h100; ack = 1'b1; ready = 1'b0;
    do_reset();
    tick();
    n_req = 0;
    for (int k = 0; k < 8; k++) begin
      if (req) n_req++;
      tick();
    end
    n_checks++; if (n_req !== 4) begin n_fail++; $display("FAIL bp_pushes got %0d exp 4", n_req); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got %b exp 0", req); end
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL bp_head got %b/%h exp 1/100", valid, instr_addr); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++; if ({req, addr} !== {1'b1, 32'h108}) begin n_fail++; $display("FAIL bp_newreq got %b/%h exp 1/108", req, addr); end
    n_checks++; if (instr_addr !== 32'h102) begin n_fail++; $display("FAIL bp_pop_head got %h exp 102", instr_addr); end
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_refull got %b exp 0", req); end
  endtask

  task automatic test_wait_states();
    boot_addr = 32'h100; ack = 1'b0; ready = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ack = 1'b1;
      n_checks++; if ({req, addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL ws_stable%0d got %b/%h exp 1/100", k, req, addr); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ws_novalid%0d got %b exp 0", k, valid); end
      tick();
    end
    ack = 1'b0;
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL ws_push got %b/%h exp 1/100", valid, instr_addr); end
    n_checks++; if (addr !== 32'h102) begin n_fail++; $display("FAIL ws_nextaddr got %h exp 102", addr); end
    tick();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ws_single_push got %b exp 0", valid); end
  endtask

  task automatic test_redirect_wait();
    boot_addr = 32'h100; ack = 1'b1; ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    n_checks++; if (addr !== 32'h104) begin n_fail++; $display("FAIL rw_pre got %h exp 104", addr); end
    ack = 1'b0; redirect = 1'b1; redirect_addr = 32'h200;
    tick();
    redirect = 1'b0;
    n_checks++; if ({valid, req, addr} !== {1'b0, 1'b1, 32'h104}) begin n_fail++; $display("FAIL rw_hold0 got %b/%b/%h exp 0/1/104", valid, req, addr); end
    tick();
    n_checks++; if ({valid, req, addr} !== {1'b0, 1'b1, 32'h104}) begin n_fail++; $display("FAIL rw_hold1 got %b/%b/%h exp 0/1/104", valid, req, addr); end
    ack = 1'b1;
    tick();
    n_checks++; if ({valid, addr} !== {1'b0, 32'h200}) begin n_fail++; $display("FAIL rw_drop got %b/%h exp 0/200", valid, addr); end
    tick();
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL rw_first got %b/%h exp 1/200", valid, instr_addr); end
    n_checks++; if (instr !== 16'hA7A5) begin n_fail++; $display("FAIL rw_instr got %h exp a7a5", instr); end
  endtask

  task automatic test_redirect_boot_ack();
    boot_addr = 32'h100; ack = 1'b1; ready = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_addr = 32'h500;
    tick();
    redirect = 1'b0;
    n_checks++; if (addr !== 32'h500) begin n_fail++; $display("FAIL rb_boot got %h exp 500", addr); end
    tick();
    tick();
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h500}) begin n_fail++; $display("FAIL rb_head got %b/%h exp 1/500", valid, instr_addr); end
    redirect = 1'b1; redirect_addr = 32'h600;
    tick();
    redirect = 1'b0;
    n_checks++; if ({valid, req, addr} !== {1'b0, 1'b1, 32'h600}) begin n_fail++; $display("FAIL ra_flush got %b/%b/%h exp 0/1/600", valid, req, addr); end
    tick();
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h600}) begin n_fail++; $display("FAIL ra_first got %b/%h exp 1/600", valid, instr_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_checks++; if (addr8 !== 8'hFE) begin n_fail++; $display("FAIL wrap_a0 got %h exp fe", addr8); end
    tick();
    n_checks++; if (addr8 !== 8'h00) begin n_fail++; $display("FAIL wrap_a1 got %h exp 00", addr8); end
    n_checks++; if ({instr_addr8, instr8} !== {8'hFE, 16'hFE01}) begin n_fail++; $display("FAIL wrap_h0 got %h/%h exp fe/fe01", instr_addr8, instr8); end
    tick();
    n_checks++; if ({instr_addr8, instr8} !== {8'h00, 16'h00FF}) begin n_fail++; $display("FAIL wrap_h1 got %h/%h exp 00/00ff", instr_addr8, instr8); end
  endtask

  task automatic test_reset_midfill();
    boot_addr = 32'h300; ack = 1'b1; ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL rm_fill got %b/%h exp 1/300", valid, instr_addr); end
    arst_n = 1'b0;
    #1;
    n_checks++; if ({req, addr} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rm_req got %b/%h exp 0/0", req, addr); end
    n_checks++; if ({valid, instr, instr_addr} !== {1'b0, 16'h0, 32'h0}) begin n_fail++; $display("FAIL rm_out got %b/%h/%h exp 0/0/0", valid, instr, instr_addr); end
    boot_addr = 32'h400;
    tick();
    tick();
    arst_n = 1'b1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rm_boot got %b exp 0", req); end
    tick();
    n_checks++; if ({req, addr, valid} !== {1'b1, 32'h400, 1'b0}) begin n_fail++; $display("FAIL rm_resume got %b/%h/%b exp 1/400/0", req, addr, valid); end
    tick();
    n_checks++; if ({valid, instr_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL rm_head got %b/%h exp 1/400", valid, instr_addr); end
  endtask

  initial begin
    arst_n = 1'b0; boot_addr = '0; ack = 1'b0; ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0;
    boot8 = 8'hFE; ack8 = 1'b1; ready8 = 1'b1; redirect8 = 1'b0; redirect_addr8 = '0;
    test_reset();
    test_boot();
    test_backpressure();
    test_wait_states();
    test_redirect_wait();
    test_redirect_boot_ack();
    test_wrap();
    test_reset_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
